// File: rtl/vae_pkg.sv
// Shared types and constants for the VAE anomaly-scoring datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vae_pkg;

    localparam int DATA_W = 16;   // signed Q6.10 feature width
    localparam int FRAC_W = 10;   // fractional bits of a feature
    localparam int N_FEAT = 9;    // features per record (1..15)
    localparam int ADDR_W = 4;    // BRAM address width
    localparam int ACC_W  = 32;   // unsigned Q22.10 score width

    // 1.0 in Q6.10
    localparam logic signed [DATA_W-1:0] ONE = 16'sh0400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of one squared-error term after dropping FRAC_W fraction bits
    function automatic int term_width(input int dw, input int fw);
        return 2 * dw + 2 - fw;
    endfunction

endpackage

// File: rtl/sq_err_unit.sv
// Squared error of one feature pair: (xref - xout)^2 >> FRAC_W, truncated.
// Latency: 2 enabled cycles (difference register, then term register).
// Backpressure: none; en=0 freezes both stages, flush empties them.
module sq_err_unit #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 10,
    parameter int TERM_W = 2 * DATA_W + 2 - FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] xref,
    input  logic [DATA_W-1:0] xout,
    output logic              mid_vld,
    output logic              out_vld,
    output logic [TERM_W-1:0] term
);

    localparam int DIFF_W = DATA_W + 1;
    localparam int SQ_W   = 2 * DATA_W + 2;

    logic signed [DIFF_W-1:0] diff_nx;
    logic signed [DIFF_W-1:0] diff;
    logic signed [SQ_W-1:0]   diff_ext;
    logic signed [SQ_W-1:0]   sq;

    // One extra bit keeps 0x7FFF - 0x8000 = 65535 exact
    assign diff_nx  = DIFF_W'($signed(xref)) - DIFF_W'($signed(xout));
    assign diff_ext = SQ_W'(diff);
    assign sq       = diff_ext * diff_ext;

    // Two-stage pipe: difference, then squared and rescaled term
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_vld <= 1'b0;
            diff    <= '0;
            out_vld <= 1'b0;
            term    <= '0;
        end else if (en) begin
            if (flush) begin
                mid_vld <= 1'b0;
                out_vld <= 1'b0;
            end else begin
                mid_vld <= in_vld;
                out_vld <= mid_vld;
                if (in_vld) begin
                    diff <= diff_nx;
                end
                // sq is never negative, so the shift is a plain truncation
                if (mid_vld) begin
                    term <= TERM_W'(sq >> FRAC_W);
                end
            end
        end
    end

endmodule

// File: rtl/recon_error_score.sv
// Reads N_FEAT original/reconstructed features, sums squared errors, flags score > threshold.
// Latency: done is high N_FEAT+3 enabled cycles after start is sampled.
// Backpressure: start only accepted while ready; en=0 stalls everything and drops BRAM enables.
module recon_error_score #(
    parameter int DATA_W = vae_pkg::DATA_W,
    parameter int FRAC_W = vae_pkg::FRAC_W,
    parameter int N_FEAT = vae_pkg::N_FEAT,
    parameter int ADDR_W = vae_pkg::ADDR_W,
    parameter int ACC_W  = vae_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              start,
    output logic              ready,
    output logic              done,
    input  logic [ACC_W-1:0]  threshold,
    output logic              xref_enb,
    output logic [ADDR_W-1:0] xref_addrb,
    input  logic [DATA_W-1:0] xref_doutb,
    output logic              xout_enb,
    output logic [ADDR_W-1:0] xout_addrb,
    input  logic [DATA_W-1:0] xout_doutb,
    output logic [ACC_W-1:0]  score,
    output logic              anomaly
);

    import vae_pkg::*;

    localparam int                TERM_W    = term_width(DATA_W, FRAC_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_FEAT - 1);

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   addr;
    logic                d1_vld;
    logic                mid_vld;
    logic                term_vld;
    logic [TERM_W-1:0]   term;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_fin;
    logic                start_ok;
    logic                drained;
    logic                finish;

    assign start_ok = (state == IDLE) && start;
    // Nothing left in flight except possibly the final term
    assign drained  = !d1_vld && !mid_vld;
    assign finish   = (state == DRAIN) && drained;
    // Final sum folds in the last term so the score is ready on the DONE entry edge
    assign acc_fin  = acc + (term_vld ? ACC_W'(term) : '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nx;
        end
    end

    // Next-state logic; clr wins over everything including start
    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nx = RUN;
                RUN:     if (addr == LAST_ADDR) state_nx = DRAIN;
                DRAIN:   if (drained) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // FSM outputs; read enables follow en so a stalled cycle issues no read
    always_comb begin
        ready    = (state == IDLE);
        done     = (state == DONE);
        xref_enb = (state == RUN) && en;
        xout_enb = (state == RUN) && en;
    end

    assign xref_addrb = addr;
    assign xout_addrb = addr;

    // Shared read address, stepping once per enabled RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (en) begin
            if (clr || start_ok) begin
                addr <= '0;
            end else if ((state == RUN) && (addr != LAST_ADDR)) begin
                addr <= addr + 1'b1;
            end
        end
    end

    // BRAM data is valid one enabled cycle after an address is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_vld <= 1'b0;
        end else if (en) begin
            d1_vld <= !clr && (state == RUN);
        end
    end

    sq_err_unit #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .TERM_W (TERM_W)
    ) u_sq_err (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .flush   (clr),
        .in_vld  (d1_vld),
        .xref    (xref_doutb),
        .xout    (xout_doutb),
        .mid_vld (mid_vld),
        .out_vld (term_vld),
        .term    (term)
    );

    // Running sum of squared-error terms for the current record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            if (clr || start_ok) begin
                acc <= '0;
            end else if (term_vld) begin
                acc <= acc_fin;
            end
        end
    end

    // Result registers: loaded on entry to DONE, held until the next record or clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score   <= '0;
            anomaly <= 1'b0;
        end else if (en) begin
            if (clr) begin
                score   <= '0;
                anomaly <= 1'b0;
            end else if (finish) begin
                score   <= acc_fin;
                anomaly <= (acc_fin > threshold);
            end
        end
    end

endmodule

// File: tb/tb_recon_error_score.sv
module tb_recon_error_score;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int ACC_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              clr;
    logic              start;
    logic              ready;
    logic              done;
    logic [ACC_W-1:0]  threshold;
    logic              xref_enb;
    logic [ADDR_W-1:0] xref_addrb;
    logic [DATA_W-1:0] xref_doutb = '0;
    logic              xout_enb;
    logic [ADDR_W-1:0] xout_addrb;
    logic [DATA_W-1:0] xout_doutb = '0;
    logic [ACC_W-1:0]  score;
    logic              anomaly;

    logic [DATA_W-1:0] mref [16];
    logic [DATA_W-1:0] mout [16];

    int n_cmp = 0;
    int n_bad = 0;

    recon_error_score dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .start      (start),
        .ready      (ready),
        .done       (done),
        .threshold  (threshold),
        .xref_enb   (xref_enb),
        .xref_addrb (xref_addrb),
        .xref_doutb (xref_doutb),
        .xout_enb   (xout_enb),
        .xout_addrb (xout_addrb),
        .xout_doutb (xout_doutb),
        .score      (score),
        .anomaly    (anomaly)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM read ports, 1-cycle latency, output held when not enabled
    always @(posedge clk) begin
        if (xref_enb) xref_doutb <= mref[xref_addrb];
        if (xout_enb) xout_doutb <= mout[xout_addrb];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, want, want);
        end
    endtask

    // Fill both memories; one optional address gets a different pair
    task automatic load(input logic [15:0] r, input logic [15:0] o,
                        input int sp_idx, input logic [15:0] sp_r, input logic [15:0] sp_o);
        for (int i = 0; i < 16; i++) begin
            mref[i] = (i == sp_idx) ? sp_r : r;
            mout[i] = (i == sp_idx) ? sp_o : o;
        end
    endtask

    // Start a record and follow it to done; en is dropped for edges
    // [stall_at, stall_at+stall_len) and start is re-pulsed before edge sp_at
    task automatic run_rec(input int stall_at, input int stall_len, input int sp_at,
                           output int lat, output int en_cnt, output int addr_bad,
                           output int rdy_cnt);
        int seq;
        lat = -1; en_cnt = 0; addr_bad = 0; rdy_cnt = 0; seq = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            en    = !((c >= stall_at) && (c < stall_at + stall_len));
            start = (c == sp_at);
            #1;
            if (done) begin
                lat = c - 1;
                break;
            end
            if (ready) rdy_cnt++;
            if (xref_enb || xout_enb) begin
                en_cnt++;
                if (!(xref_enb && xout_enb) || (xref_addrb != ADDR_W'(seq)) ||
                    (xout_addrb != ADDR_W'(seq)))
                    addr_bad++;
                seq++;
            end
            @(posedge clk); #1;
        end
        en    = 1'b1;
        start = 1'b0;
    endtask

    // Checks a full record plus the cycle after done
    task automatic do_case(input string tag, input int stall_at, input int stall_len,
                           input int sp_at, input int want_lat,
                           input logic [31:0] want_score, input logic want_an);
        int lat, en_cnt, addr_bad, rdy_cnt;
        run_rec(stall_at, stall_len, sp_at, lat, en_cnt, addr_bad, rdy_cnt);
        check({tag, "_latency"}, 32'(lat), 32'(want_lat));
        check({tag, "_score"}, score, want_score);
        check({tag, "_anomaly"}, 32'(anomaly), 32'(want_an));
        check({tag, "_rd_cycles"}, 32'(en_cnt), 32'd9);
        check({tag, "_addr_seq_err"}, 32'(addr_bad), 32'd0);
        check({tag, "_ready_busy"}, 32'(rdy_cnt), 32'd0);
        check({tag, "_ready_in_done"}, 32'(ready), 32'd0);
        @(posedge clk); #1;
        check({tag, "_ready_after"}, 32'(ready), 32'd1);
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_score_hold"}, score, want_score);
    endtask

    task automatic watch_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; start = 1'b0; threshold = '0;
        load(16'h0400, 16'h0400, -1, 16'h0, 16'h0);
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_score", score, 32'd0);
        check("rst_anomaly", 32'(anomaly), 32'd0);
        check("rst_enb", 32'({xref_enb, xout_enb}), 32'd0);
        check("rst_addr", 32'({xref_addrb, xout_addrb}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Perfect reconstruction
        threshold = 32'd0;
        do_case("zero_err", 0, 0, 0, 12, 32'd0, 1'b0);

        // 1.0 error everywhere: 9 * 1024
        load(16'h0400, 16'h0000, -1, 16'h0, 16'h0);
        threshold = 32'd4096;
        do_case("unit_err", 0, 0, 0, 12, 32'd9216, 1'b1);

        // Single -3.0 error at address 4: 3072^2 >> 10 = 9216, threshold boundary
        load(16'h0400, 16'h0400, 4, 16'hF800, 16'h0400);
        threshold = 32'd9216;
        do_case("one_err_eq", 0, 0, 0, 12, 32'd9216, 1'b0);
        threshold = 32'd9215;
        do_case("one_err_lt", 0, 0, 0, 12, 32'd9216, 1'b1);

        // Extreme difference 65535: 4194176 per element, 37747584 total
        load(16'h7FFF, 16'h8000, -1, 16'h0, 16'h0);
        threshold = 32'd37747584;
        do_case("max_err", 0, 0, 0, 12, 32'd37747584, 1'b0);

        // Stall three edges mid-run plus an ignored start pulse
        load(16'h0400, 16'h0000, -1, 16'h0, 16'h0);
        threshold = 32'd4096;
        do_case("stall", 4, 3, 3, 15, 32'd9216, 1'b1);

        // Asynchronous reset mid-run
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_score", score, 32'd0);
        check("arst_anomaly", 32'(anomaly), 32'd0);
        check("arst_enb", 32'(xref_enb), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        watch_done(20, dcnt);
        check("arst_no_done", 32'(dcnt), 32'd0);

        do_case("post_rst", 0, 0, 0, 12, 32'd9216, 1'b1);

        // Synchronous clear mid-run
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_ready", 32'(ready), 32'd1);
        check("clr_score", score, 32'd0);
        check("clr_anomaly", 32'(anomaly), 32'd0);
        watch_done(20, dcnt);
        check("clr_no_done", 32'(dcnt), 32'd0);

        // clr beats start in IDLE
        clr = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0;
        check("clr_start_ready", 32'(ready), 32'd1);
        watch_done(20, dcnt);
        check("clr_start_no_done", 32'(dcnt), 32'd0);

        do_case("post_clr", 0, 0, 0, 12, 32'd9216, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
